// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
//   FETCH_DEPTH  default prefetch queue depth
//   INSTR_BYTES  byte stride between consecutive instructions
//   MEM_LATENCY  cycles from read_request to data_valid
//   track_t      per-request tracking record. valid is the MSB because
//                pipeline reports stage occupancy from that bit.
//   queue_entry_t  one prefetch queue slot
package fetch_pkg;

  localparam int FETCH_DEPTH = 4;
  localparam int INSTR_BYTES = 4;
  localparam int MEM_LATENCY = 2;

  typedef struct packed {
    logic        valid;
    logic        drop;
    logic [31:0] pc;
  } track_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } queue_entry_t;

endpackage

// File: rtl/program_memory_bus.sv
// Instruction memory read bus.
//   addr/read_request : request from the fetch unit
//   instr/data_valid  : response from memory, fixed latency
interface program_memory_bus;
  logic [31:0] addr;
  logic        read_request;
  logic [31:0] instr;
  logic        data_valid;

  modport CONSUMER_A (output addr, output read_request, input instr, input data_valid);
  modport PROVIDER_A (input addr, input read_request, output instr, output data_valid);
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} with wrapping pointers.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the queue; wins over push and pop
//   push       : write push_entry at the tail
//   pop        : advance the head
//   head       : entry at the head (meaningful only when count != 0)
//   count      : number of valid entries, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  queue_entry_t           push_entry,
  input  logic                   pop,
  output queue_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  queue_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: head is qualified by count.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr] <= push_entry;
  end

  assign head = mem_q[rd_ptr];

endmodule

// File: rtl/pipeline.sv
// Generic shift-register pipeline of STAGES stages.
//   clk, rst   : clock, synchronous active-high reset (clears every stage)
//   mark_en    : OR mark_mask into every entry as it advances this cycle
//   mark_mask  : bits to set on the entries in flight
//   d          : entry entering stage 0
//   q          : entry in the last stage
//   busy       : per-stage occupancy, taken from the MSB of each stage
module pipeline #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mark_en,
  input  logic [WIDTH-1:0]  mark_mask,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic [STAGES-1:0] busy
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1] | (mark_en ? mark_mask : '0);
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < STAGES; i++) begin
      busy[i] = stage_q[i][WIDTH-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetch unit with a small queue and redirect support.
//   clk_in, rst_in     : clock, synchronous active-high reset
//   mem                : instruction memory read port (2-cycle latency)
//   redirect_valid_in  : flush and restart fetch at redirect_pc_in
//   redirect_pc_in     : redirect byte address (low two bits ignored)
//   instr_valid_out    : queue head valid
//   instr_out, pc_out  : head instruction and its byte address
//   instr_ready_in     : consumer takes the head this cycle
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  program_memory_bus.CONSUMER_A mem,
  input  logic                  redirect_valid_in,
  input  logic [31:0]           redirect_pc_in,
  output logic                  instr_valid_out,
  output logic [31:0]           instr_out,
  output logic [31:0]           pc_out,
  input  logic                  instr_ready_in
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int IW = $clog2(MEM_LATENCY + 1);
  localparam track_t DROP_MASK = '{valid: 1'b0, drop: 1'b1, pc: 32'h0};

  logic [31:0]            fetch_pc;
  logic [CW-1:0]          count;
  logic [MEM_LATENCY-1:0] busy;
  logic [IW-1:0]          inflight;
  logic [OW-1:0]          occupancy;
  logic                   pop;
  logic                   push;
  logic                   issue;
  track_t                 track_in;
  track_t                 track_last;
  queue_entry_t           head;
  queue_entry_t           push_entry;
  logic [1:0]             rst_hist;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + IW'(busy[i]);
    end
  end

  assign pop = instr_valid_out && instr_ready_in && !redirect_valid_in;

  // The entry popped this cycle frees its slot before any new response can
  // land, so it is credited immediately; this keeps one instruction per
  // cycle flowing at DEPTH = 3.
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);
  assign issue     = !rst_in && !redirect_valid_in && (occupancy < OW'(DEPTH));

  assign mem.read_request = issue;
  assign mem.addr         = issue ? fetch_pc : 32'h0;

  always_ff @(posedge clk_in) begin
    if (rst_in)                 fetch_pc <= RESET_PC;
    else if (redirect_valid_in) fetch_pc <= redirect_pc_in & ~32'h3;
    else if (issue)             fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
  end

  assign track_in = '{valid: issue, drop: 1'b0, pc: fetch_pc};

  // Entries advancing during a redirect get their drop bit set, so every
  // response in flight at that edge is discarded on arrival.
  pipeline #(
    .WIDTH  ($bits(track_t)),
    .STAGES (MEM_LATENCY)
  ) u_track (
    .clk       (clk_in),
    .rst       (rst_in),
    .mark_en   (redirect_valid_in),
    .mark_mask (DROP_MASK),
    .d         (track_in),
    .q         (track_last),
    .busy      (busy)
  );

  assign push = mem.data_valid && track_last.valid && !track_last.drop &&
                !redirect_valid_in && !rst_in;
  assign push_entry = '{pc: track_last.pc, instr: mem.instr};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk_in),
    .rst        (rst_in),
    .flush      (redirect_valid_in),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign instr_valid_out = !rst_in && (count != '0);
  assign instr_out       = instr_valid_out ? head.instr : 32'h0;
  assign pc_out          = instr_valid_out ? head.pc    : 32'h0;

  // Responses to requests issued before a reset still arrive for up to
  // MEM_LATENCY cycles afterward; they are legitimately untracked.
  always_ff @(posedge clk_in) begin
    if (rst_in) rst_hist <= 2'b11;
    else        rst_hist <= {rst_hist[0], 1'b0};
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && (rst_hist == 2'b00) && mem.data_valid) begin
      assert (track_last.valid);
    end
  end

endmodule
